// File: rtl/dm_lsu.sv
// Load/store unit between the core and the data memory: range/type checks, single-beat
// aligned accesses, byte-split misaligned accesses, and a registered response.
module dm_lsu #(
    parameter int unsigned MEM_BYTES        = 8192,
    parameter bit          ALLOW_MISALIGNED = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  req_ctrl,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_fault,
    output logic        dm_we,
    output logic [2:0]  dm_ctrl,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    input  logic [31:0] dm_rdata
);

    typedef enum logic {IDLE = 1'b0, SPLIT = 1'b1} state_t;

    state_t      state, state_nxt;
    logic [1:0]  idx;
    logic [31:0] byte_buf;
    logic [31:0] base_q;
    logic [31:0] wdata_q;
    logic [2:0]  ctrl_q;
    logic        we_q;

    logic [2:0]  req_size;
    logic [32:0] end_addr;
    logic        ctrl_bad, oob, misaligned, fault;
    logic        accept, go_direct, go_split;
    logic [1:0]  last_idx;
    logic        last_beat;
    logic [4:0]  bsel;
    logic [31:0] assembled, ext_data;
    logic        we_int;

    always_comb begin
        case (req_ctrl[1:0])
            2'b00:   req_size = 3'd1;
            2'b01:   req_size = 3'd2;
            default: req_size = 3'd4;
        endcase
    end

    // End address computed one bit wider so addresses near 2^32 cannot wrap into range
    assign end_addr   = {1'b0, req_addr} + {30'd0, req_size} - 33'd1;
    assign oob        = end_addr >= 33'(MEM_BYTES);
    assign ctrl_bad   = (req_ctrl[1:0] == 2'b11) || (req_ctrl[2] && req_ctrl[1]) ||
                        (req_we && req_ctrl[2]);
    assign misaligned = ((req_ctrl[1:0] == 2'b01) && req_addr[0]) ||
                        ((req_ctrl[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    assign fault      = ctrl_bad || oob || (misaligned && !ALLOW_MISALIGNED);

    assign accept    = (state == IDLE) && req_valid;
    assign go_direct = accept && !fault && !misaligned;
    assign go_split  = accept && !fault && misaligned;

    assign last_idx  = (ctrl_q[1:0] == 2'b01) ? 2'd1 : 2'd3;
    assign last_beat = (state == SPLIT) && (idx == last_idx);
    assign bsel      = {idx, 3'b000};

    // Final byte arrives on the last beat, so merge it before extension
    always_comb begin
        assembled             = byte_buf;
        assembled[bsel +: 8]  = dm_rdata[7:0];
    end

    always_comb begin
        case (ctrl_q)
            3'b001:  ext_data = {{16{assembled[15]}}, assembled[15:0]};
            3'b101:  ext_data = {16'd0, assembled[15:0]};
            default: ext_data = assembled;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // FSM next state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (go_split)  state_nxt = SPLIT;
            SPLIT:   if (last_beat) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs: dm port and ready
    always_comb begin
        req_ready = (state == IDLE);
        we_int    = 1'b0;
        dm_ctrl   = 3'b010;
        dm_addr   = 32'd0;
        dm_wdata  = 32'd0;
        if (go_direct) begin
            we_int   = req_we;
            dm_ctrl  = req_ctrl;
            dm_addr  = req_addr;
            dm_wdata = req_wdata;
        end else if (state == SPLIT) begin
            we_int   = we_q;
            dm_ctrl  = we_q ? 3'b000 : 3'b100;
            dm_addr  = base_q + {30'd0, idx};
            dm_wdata = {24'd0, wdata_q[bsel +: 8]};
        end
        dm_we = we_int && rst_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx       <= 2'd0;
            byte_buf  <= 32'd0;
            base_q    <= 32'd0;
            wdata_q   <= 32'd0;
            ctrl_q    <= 3'd0;
            we_q      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_fault <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_fault <= 1'b0;
            if (accept) begin
                if (fault) begin
                    rsp_valid <= 1'b1;
                    rsp_fault <= 1'b1;
                    rsp_rdata <= 32'd0;
                end else if (misaligned) begin
                    base_q   <= req_addr;
                    ctrl_q   <= req_ctrl;
                    we_q     <= req_we;
                    wdata_q  <= req_wdata;
                    idx      <= 2'd0;
                    byte_buf <= 32'd0;
                end else begin
                    rsp_valid <= 1'b1;
                    rsp_rdata <= req_we ? 32'd0 : dm_rdata;
                end
            end else if (state == SPLIT) begin
                idx <= idx + 2'd1;
                if (!we_q) byte_buf <= assembled;
                if (last_beat) begin
                    idx       <= 2'd0;
                    rsp_valid <= 1'b1;
                    rsp_rdata <= we_q ? 32'd0 : ext_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_dm_lsu.sv
// Bench for dm_lsu: a byte-array data memory plus a byte-level reference model of
// expected responses, latencies and memory contents.
module tb_dm_lsu;

    localparam int MEM_BYTES = 8192;

    logic        clk, rst_n;
    logic        req_valid, req_we;
    logic [2:0]  req_ctrl;
    logic [31:0] req_addr, req_wdata;
    logic        req_ready, rsp_valid, rsp_fault;
    logic [31:0] rsp_rdata;
    logic        dm_we;
    logic [2:0]  dm_ctrl;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;

    logic [7:0]  mem     [0:MEM_BYTES-1];
    logic [7:0]  ref_mem [0:MEM_BYTES-1];
    logic        load_mem;

    int n_cmp = 0;
    int n_err = 0;

    dm_lsu #(.MEM_BYTES(MEM_BYTES), .ALLOW_MISALIGNED(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_we(req_we), .req_ctrl(req_ctrl),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault),
        .dm_we(dm_we), .dm_ctrl(dm_ctrl), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_rdata(dm_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory: combinational extended read, clocked write
    logic [12:0] a0;
    logic [7:0]  b0, b1, b2, b3;
    always_comb begin
        a0 = dm_addr[12:0];
        b0 = mem[a0];
        b1 = mem[a0 + 13'd1];
        b2 = mem[a0 + 13'd2];
        b3 = mem[a0 + 13'd3];
        dm_rdata = 32'd0;
        case (dm_ctrl)
            3'b000:  dm_rdata = {{24{b0[7]}}, b0};
            3'b001:  dm_rdata = {{16{b1[7]}}, b1, b0};
            3'b010:  dm_rdata = {b3, b2, b1, b0};
            3'b100:  dm_rdata = {24'd0, b0};
            3'b101:  dm_rdata = {16'd0, b1, b0};
            default: dm_rdata = 32'd0;
        endcase
    end

    always @(posedge clk) begin
        if (load_mem) begin
            for (int i = 0; i < MEM_BYTES; i++) mem[i] <= ref_mem[i];
        end else if (dm_we) begin
            case (dm_ctrl)
                3'b000: mem[a0] <= dm_wdata[7:0];
                3'b001: begin
                    mem[a0]         <= dm_wdata[7:0];
                    mem[a0 + 13'd1] <= dm_wdata[15:8];
                end
                3'b010: begin
                    mem[a0]         <= dm_wdata[7:0];
                    mem[a0 + 13'd1] <= dm_wdata[15:8];
                    mem[a0 + 13'd2] <= dm_wdata[23:16];
                    mem[a0 + 13'd3] <= dm_wdata[31:24];
                end
                default: ;
            endcase
        end
    end

    // Reference: decides fault, data, latency and stall length from the access rules
    task automatic ref_model(input logic we, input logic [2:0] ctrl, input logic [31:0] addr,
                             input logic [31:0] wdata, output bit flt, output logic [31:0] rd,
                             output int lat, output int low, output int n, output bit mis);
        bit bad;
        longint unsigned last;
        logic [31:0] v;
        n    = (ctrl[1:0] == 2'b00) ? 1 : (ctrl[1:0] == 2'b01) ? 2 : 4;
        bad  = (ctrl[1:0] == 2'b11) || (ctrl == 3'b110) || (ctrl == 3'b111) || (we && ctrl[2]);
        last = {32'd0, addr} + 64'(n) - 64'd1;
        mis  = (addr % 32'(n)) != 0;
        flt  = bad || (last >= 64'(MEM_BYTES));
        rd = 32'd0; lat = 1; low = 0;
        if (flt) return;
        if (mis) begin lat = n + 1; low = n; end
        if (we) begin
            for (int b = 0; b < n; b++) ref_mem[int'(addr) + b] = wdata[8*b +: 8];
        end else begin
            v = 32'd0;
            for (int b = 0; b < n; b++) v[8*b +: 8] = ref_mem[int'(addr) + b];
            if (!ctrl[2] && n < 4 && v[8*n-1]) v = v | (32'hFFFFFFFF << (8*n));
            rd = v;
        end
    endtask

    task automatic do_req(input string tag, input logic we, input logic [2:0] ctrl,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] got_rd);
        bit flt, mis, got;
        logic [31:0] exp_rd;
        int lat, low, n, seen_low, cyc;
        ref_model(we, ctrl, addr, wdata, flt, exp_rd, lat, low, n, mis);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_ctrl = ctrl; req_addr = addr; req_wdata = wdata;
        #1;
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_err++; $display("FAIL %s req_ready got %b want 1", tag, req_ready);
        end
        n_cmp++;
        if (flt || mis) begin
            if (dm_we !== 1'b0) begin
                n_err++; $display("FAIL %s accept_dm_we got %b want 0", tag, dm_we);
            end
        end else if (dm_we !== we || dm_addr !== addr) begin
            n_err++; $display("FAIL %s direct_port got we=%b addr=%h want we=%b addr=%h",
                              tag, dm_we, dm_addr, we, addr);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        got = 0; seen_low = 0; cyc = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) begin got = 1; cyc = c; break; end
            if (req_ready === 1'b0) seen_low++;
        end
        got_rd = rsp_rdata;
        n_cmp++;
        if (!got) begin
            n_err++; $display("FAIL %s rsp_timeout got none want latency %0d", tag, lat);
        end else begin
            n_cmp++;
            if (cyc != lat) begin
                n_err++; $display("FAIL %s latency got %0d want %0d", tag, cyc, lat);
            end
            n_cmp++;
            if (rsp_fault !== flt || rsp_rdata !== exp_rd) begin
                n_err++; $display("FAIL %s rsp got fault=%b rdata=%h want fault=%b rdata=%h",
                                  tag, rsp_fault, rsp_rdata, flt, exp_rd);
            end
        end
        n_cmp++;
        if (seen_low != low) begin
            n_err++; $display("FAIL %s stall_cycles got %0d want %0d", tag, seen_low, low);
        end
        @(negedge clk);
        n_cmp++;
        if (rsp_valid !== 1'b0 || rsp_fault !== 1'b0) begin
            n_err++; $display("FAIL %s rsp_clear got valid=%b fault=%b want 0/0",
                              tag, rsp_valid, rsp_fault);
        end
        if (we && !flt) begin
            for (int b = 0; b < n; b++) begin
                n_cmp++;
                if (mem[int'(addr) + b] !== ref_mem[int'(addr) + b]) begin
                    n_err++; $display("FAIL %s mem[%h] got %h want %h", tag, int'(addr) + b,
                                      mem[int'(addr) + b], ref_mem[int'(addr) + b]);
                end
            end
        end
    endtask

    task automatic sync_mem();
        @(negedge clk); load_mem = 1'b1;
        @(negedge clk); load_mem = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        n_cmp++;
        if (rsp_valid !== 1'b0 || rsp_fault !== 1'b0 || rsp_rdata !== 32'd0) begin
            n_err++; $display("FAIL reset_rsp got v=%b f=%b d=%h want 0/0/0",
                              rsp_valid, rsp_fault, rsp_rdata);
        end
        n_cmp++;
        if (dm_we !== 1'b0 || dm_ctrl !== 3'b010 || dm_addr !== 32'd0 || dm_wdata !== 32'd0) begin
            n_err++; $display("FAIL reset_dm got we=%b ctrl=%b addr=%h wd=%h want 0/010/0/0",
                              dm_we, dm_ctrl, dm_addr, dm_wdata);
        end
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_err++; $display("FAIL reset_ready got %b want 1", req_ready);
        end
    endtask

    task automatic test_aligned();
        logic [31:0] rd;
        do_req("sw_aligned", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, rd);
        do_req("lw_aligned", 1'b0, 3'b010, 32'h10, 32'h0, rd);
        n_cmp++;
        if (rd !== 32'hDEADBEEF) begin
            n_err++; $display("FAIL lw_aligned_const got %h want deadbeef", rd);
        end
    endtask

    task automatic test_misaligned();
        logic [31:0] rd;
        do_req("sw_split", 1'b1, 3'b010, 32'h21, 32'h11223344, rd);
        do_req("lw_split", 1'b0, 3'b010, 32'h21, 32'h0, rd);
        n_cmp++;
        if (rd !== 32'h11223344) begin
            n_err++; $display("FAIL lw_split_const got %h want 11223344", rd);
        end
        ref_mem[3] = 8'h80; ref_mem[4] = 8'hFF;
        sync_mem();
        do_req("lh_split", 1'b0, 3'b001, 32'h3, 32'h0, rd);
        n_cmp++;
        if (rd !== 32'hFFFFFF80) begin
            n_err++; $display("FAIL lh_split_const got %h want ffffff80", rd);
        end
        do_req("lhu_split", 1'b0, 3'b101, 32'h3, 32'h0, rd);
        n_cmp++;
        if (rd !== 32'h0000FF80) begin
            n_err++; $display("FAIL lhu_split_const got %h want 0000ff80", rd);
        end
    endtask

    task automatic test_faults();
        logic [31:0] rd;
        do_req("lw_oob", 1'b0, 3'b010, 32'h1FFE, 32'h0, rd);
        do_req("st_ctrl100", 1'b1, 3'b100, 32'h10, 32'h12345678, rd);
        do_req("ld_ctrl011", 1'b0, 3'b011, 32'h10, 32'h0, rd);
        do_req("sb_last", 1'b1, 3'b000, 32'h1FFF, 32'h000000A5, rd);
        do_req("sw_wrap", 1'b1, 3'b010, 32'hFFFFFFFC, 32'h1, rd);
    endtask

    task automatic test_reset_split();
        logic [7:0] prev [4];
        for (int b = 0; b < 4; b++) prev[b] = ref_mem[32'h41 + b];
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_ctrl = 3'b010;
        req_addr = 32'h41; req_wdata = 32'hAABBCCDD;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (dm_we !== 1'b1 || dm_addr !== 32'h41 || dm_wdata !== 32'h000000DD) begin
            n_err++; $display("FAIL rst_beat0 got we=%b addr=%h wd=%h want 1/41/dd",
                              dm_we, dm_addr, dm_wdata);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (dm_we !== 1'b0) begin
            n_err++; $display("FAIL rst_dm_we got %b want 0", dm_we);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            n_err++; $display("FAIL rst_release got ready=%b valid=%b want 1/0", req_ready, rsp_valid);
        end
        repeat (4) begin
            @(negedge clk);
            n_cmp++;
            if (rsp_valid !== 1'b0) begin
                n_err++; $display("FAIL rst_no_rsp got %b want 0", rsp_valid);
            end
        end
        ref_mem[32'h41] = 8'hDD;
        for (int b = 0; b < 4; b++) begin
            n_cmp++;
            if (mem[32'h41 + b] !== ((b == 0) ? 8'hDD : prev[b])) begin
                n_err++; $display("FAIL rst_mem[%0d] got %h want %h", b, mem[32'h41 + b],
                                  (b == 0) ? 8'hDD : prev[b]);
            end
        end
    endtask

    task automatic test_back_to_back();
        bit flt, mis;
        logic [31:0] rd;
        int lat, low, n;
        logic [7:0] d [3];
        for (int i = 0; i < 3; i++) begin
            d[i] = 8'($urandom);
            ref_model(1'b1, 3'b000, 32'(i), {24'd0, d[i]}, flt, rd, lat, low, n, mis);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i > 0) begin
                n_cmp++;
                if (rsp_valid !== 1'b1) begin
                    n_err++; $display("FAIL b2b_rsp%0d got %b want 1", i, rsp_valid);
                end
            end
            if (i < 3) begin
                req_valid = 1'b1; req_we = 1'b1; req_ctrl = 3'b000;
                req_addr = 32'(i); req_wdata = {24'h5A5A5A, d[i]};
                #1;
                n_cmp++;
                if (req_ready !== 1'b1) begin
                    n_err++; $display("FAIL b2b_ready%0d got %b want 1", i, req_ready);
                end
            end else begin
                req_valid = 1'b0;
            end
        end
        @(negedge clk);
        n_cmp++;
        if (rsp_valid !== 1'b0) begin
            n_err++; $display("FAIL b2b_clear got %b want 0", rsp_valid);
        end
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (mem[i] !== d[i]) begin
                n_err++; $display("FAIL b2b_mem[%0d] got %h want %h", i, mem[i], d[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, addr;
        logic [2:0]  ctrl;
        logic        we;
        for (int k = 0; k < 60; k++) begin
            ctrl = 3'($urandom_range(0, 7));
            we   = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 4))
                0:       addr = 32'($urandom);
                1:       addr = 32'(MEM_BYTES - 4 + $urandom_range(0, 3));
                default: addr = 32'($urandom_range(0, 95));
            endcase
            do_req("random", we, ctrl, addr, 32'($urandom), rd);
        end
    endtask

    initial begin
        rst_n = 1'b0; load_mem = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_ctrl = 3'b000;
        req_addr = 32'd0; req_wdata = 32'd0;
        for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = 8'($urandom);
        repeat (2) @(posedge clk);
        @(negedge clk);
        load_mem = 1'b0;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        test_aligned();
        test_misaligned();
        test_faults();
        test_reset_split();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
